// File: rtl/chan_pkg.sv
// chan_pkg -- shared definitions for the clocked channel endpoints.
//
// Contents:
//   CHAN_WIDTH_DEFAULT, CHAN_DEPTH_DEFAULT, CHAN_SYNC_DEFAULT
//                 default channel token width, receive FIFO depth and
//                 request synchronizer length
//   hs_state_t    4-phase receive handshake states (IDLE=0, ACKH=1, WAITL=2)
package chan_pkg;

   localparam int CHAN_WIDTH_DEFAULT = 1;
   localparam int CHAN_DEPTH_DEFAULT = 4;
   localparam int CHAN_SYNC_DEFAULT  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACKH  = 2'd1,
      WAITL = 2'd2
   } hs_state_t;

endpackage

// File: rtl/sync_ff.sv
// sync_ff -- multi-flop synchronizer for a single asynchronous level signal.
//
// Parameters:
//   STAGES  number of flops in the chain (at least 2)
// Ports:
//   clk     destination clock
//   rst_n   asynchronous active-low reset, clears every stage to 0
//   d       asynchronous input level
//   q       synchronized level, STAGES clock edges behind d
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/chan_rx_sync.sv
// chan_rx_sync -- receive endpoint of a 4-phase bundled-data channel.
// Tokens from an asynchronous sender are captured into a small circular FIFO
// read by a synchronous consumer.
//
// Optional feature: define CHAN_RX_PARITY_EN to add even-parity checking
// (ports in_par and par_err).
//
// Parameters:
//   WIDTH        data bits per token
//   DEPTH        FIFO entries (power of two, >= 2)
//   SYNC_STAGES  synchronizer flops on in_req (>= 2)
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   in_req       4-phase request, asynchronous to clk
//   in_data      token data, stable from in_req rise until in_ack rise
//   in_ack       4-phase acknowledge, straight from a flop
//   out_data     head-of-FIFO token (combinational read)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head token
//   level        FIFO occupancy
//   in_par       (CHAN_RX_PARITY_EN) even parity over in_data
//   par_err      (CHAN_RX_PARITY_EN) sticky parity error flag
//   dbg_state    current handshake FSM state
//
// Handshakes: on the consumer side a token transfers on every rising edge
// where out_valid and out_ready are both high; out_valid does not depend on
// out_ready. On the sender side one full req-up/ack-up/req-down/ack-down
// cycle delivers exactly one token, pushed on the edge that raises in_ack.
module chan_rx_sync
   import chan_pkg::*;
#(
   parameter int WIDTH       = CHAN_WIDTH_DEFAULT,
   parameter int DEPTH       = CHAN_DEPTH_DEFAULT,
   parameter int SYNC_STAGES = CHAN_SYNC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_req,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ack,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
`ifdef CHAN_RX_PARITY_EN
   input  logic                     in_par,
   output logic                     par_err,
`endif
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic             req_s;
   hs_state_t        state_q, state_d;
   logic             ack_q, ack_d;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             full, empty, push, pop;

   // in_req is only ever looked at through this synchronizer.
   sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (in_req),
      .q     (req_s)
   );

   // Wrap bit differs with equal index -> full; identical pointers -> empty.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign push  = (state_q == IDLE) && req_s && !full;
   assign pop   = out_ready && !empty;

   // Handshake FSM: next state and next acknowledge.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            // A full FIFO simply holds us here; the request stays pending.
            if (push) begin
               state_d = ACKH;
               ack_d   = 1'b1;
            end
         end
         ACKH: begin
            state_d = WAITL;
            ack_d   = 1'b1;
         end
         WAITL: begin
            if (!req_s) begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

`ifdef CHAN_RX_PARITY_EN
   logic par_err_q;

   // The token is still stored and acknowledged; the error is only flagged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           par_err_q <= 1'b0;
      else if (push && ((^in_data) != in_par)) par_err_q <= 1'b1;
   end

   assign par_err = par_err_q;
`endif

   assign in_ack    = ack_q;
   assign out_data  = mem[rd_ptr[AW-1:0]];
   assign out_valid = !empty;
   assign level     = wr_ptr - rd_ptr;
   assign dbg_state = state_q;

endmodule

// File: doc/chan_rx_sync.md
CHAN_RX_SYNC -- requirements
Module: chan_rx_sync

Interface
REQ-001 Parameter WIDTH, default 1: data bits per channel token.
REQ-002 Parameter DEPTH, default 4: receive FIFO entries, power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2: flop stages on in_req, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-006 Port in_req, input, 1: 4-phase bundled-data request from the asynchronous sender; asynchronous to clk.
REQ-007 Port in_data, input, WIDTH: channel data, stable from in_req rise until in_ack rise.
REQ-008 Port in_ack, output, 1: 4-phase acknowledge, driven directly from a flop.
REQ-009 Port out_data, output, WIDTH: head-of-FIFO token.
REQ-010 Port out_valid, output, 1: FIFO non-empty.
REQ-011 Port out_ready, input, 1: consumer accepts the token; a pop occurs when out_valid and out_ready are both high.
REQ-012 Port level, output, clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-013 in_req SHALL pass through SYNC_STAGES flops; the result is req_s, and no other logic samples in_req.
REQ-014 The handshake FSM SHALL have exactly three states: IDLE, ACKH and WAITL.
REQ-015 IDLE, with req_s=1 and FIFO not full: push in_data, set in_ack=1, go to ACKH, all on the same edge.
REQ-016 IDLE, with req_s=1 and FIFO full: stay in IDLE, in_ack=0; the push happens on the first edge after a slot frees.
REQ-017 ACKH: go to WAITL unconditionally on the next edge; in_ack stays 1.
REQ-018 WAITL, with req_s=0: clear in_ack and go to IDLE; otherwise hold.
REQ-019 Latency: in_req rising before edge k gives the push and in_ack=1 at edge k+SYNC_STAGES, and out_valid=1 at the same edge if the FIFO was empty.
REQ-020 Each 4-phase cycle SHALL push exactly one token; no duplicates and no drops.
REQ-021 The FIFO SHALL be a circular buffer; pointers are clog2(DEPTH)+1 bits with wrap-bit full/empty detection.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; when full, a pop on edge k allows a push at edge k+1 at the earliest.
REQ-023 out_data SHALL show the head entry combinationally from the storage array; with out_valid=0 its value is don't-care.
REQ-024 Popping while empty, or pushing while full, SHALL never change state.

Reset
REQ-025 reset=0 asynchronously sets: FSM to IDLE, in_ack=0, synchronizer flops to 0, pointers to 0, level=0, out_valid=0.
REQ-026 Reset released mid-handshake (in_req still 1): FSM starts in IDLE and treats the request as new; the sender is responsible for not holding stale requests across reset.
REQ-027 Reset release SHALL take effect synchronously at the next clk edge; the release is synchronized externally.

Configuration
REQ-028 Macro CHAN_RX_PARITY_EN, when defined, adds port in_par (input, 1, even parity over in_data, bundled with in_data) and port par_err (output, 1).
REQ-029 With CHAN_RX_PARITY_EN defined, a push whose parity mismatches SHALL still store and acknowledge the token and SHALL set sticky par_err=1 on the push edge; only reset clears par_err.
REQ-030 Without CHAN_RX_PARITY_EN, in_par and par_err do not exist and no parity logic is synthesized.

Structure
REQ-031 The FSM state encodings (IDLE=2'd0, ACKH=2'd1, WAITL=2'd2) SHALL live in shared header chan_pkg, next to the channel width macros.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_ff (parameter STAGES, async active-low reset), reused by the other clocked channel endpoints.
REQ-033 The FIFO storage and pointers SHALL be inline in chan_rx_sync; no separate FIFO module.

Verification
REQ-034 Single token: reset pulse, then send in_data=1 with out_ready=1 -> in_ack rises 2 edges after in_req; out_data=1, out_valid pulses 1 cycle; level returns to 0.
REQ-035 Sequence 0,1,1 with out_ready=1 -> popped order is exactly 0,1,1; three ack cycles; no extra pops.
REQ-036 Backpressure: out_ready=0, send 5 tokens with DEPTH=4 -> level=4 and the 5th in_ack stays 0; raise out_ready for one cycle -> 5th token acknowledged next edge, level=4 again.
REQ-037 Reset asserted while in ACKH -> in_ack=0 and level=0 immediately, without waiting for a clock edge; after release, a fresh send completes normally.
REQ-038 With CHAN_RX_PARITY_EN: send in_data=1 with in_par=0 -> token delivered and par_err=1, staying 1 until reset; a correct-parity send afterwards leaves par_err=1.
REQ-039 Continuous send with random out_ready over more than 2*DEPTH tokens -> pointers wrap; the scoreboard shows in-order, lossless delivery.
